// File: rtl/capture_ctrl.sv
// Capture controller for an external 4-bit counter.
// It snapshots the counter value on the cycle after it leaves TERM, with ack/overrun handshaking.
module capture_ctrl #(
  parameter logic [3:0] TERM = 4'b1111,
  parameter int         CW   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [3:0]    Q,
  output logic          cnt_en,
  output logic          cnt_clr,
  output logic          QFlag,
  output logic [3:0]    Qreg,
  output logic          cap_valid,
  input  logic          cap_ack,
  output logic [CW-1:0] cap_count,
  output logic          overrun,
  output logic          busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]    state_q, state_d;
  logic          qflag_q, qflag_d;
  logic [3:0]    qreg_q, qreg_d;
  logic          cap_valid_q, cap_valid_d;
  logic [CW-1:0] cap_count_q, cap_count_d;
  logic          overrun_q, overrun_d;
  logic          capture;
  logic          session_clr;

  always_comb begin
    qflag_d = (Q == TERM);
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = stop ? IDLE : RUN;
      RUN: begin
        if (stop)         state_d = IDLE;
        else if (qflag_d) state_d = HOLD;
      end
      HOLD: begin
        if (stop)          state_d = IDLE;
        else if (!qflag_d) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Falling edge of the registered flag, only while waiting in HOLD; stop suppresses it.
  assign capture     = (state_q == HOLD) && qflag_q && !qflag_d && !stop;
  assign session_clr = (state_q == IDLE) && start;

  always_comb begin
    qreg_d      = qreg_q;
    cap_valid_d = cap_valid_q;
    cap_count_d = cap_count_q;
    overrun_d   = overrun_q;
    if (session_clr) begin
      cap_count_d = '0;
      overrun_d   = 1'b0;
    end
    if (capture) begin
      if (cap_count_q != CNT_MAX) cap_count_d = cap_count_q + CNT_ONE;
      if (!cap_valid_q || cap_ack) begin
        qreg_d      = Q;
        cap_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (cap_valid_q && cap_ack) begin
      cap_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      qflag_q     <= 1'b0;
      qreg_q      <= 4'd0;
      cap_valid_q <= 1'b0;
      cap_count_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      qflag_q     <= qflag_d;
      qreg_q      <= qreg_d;
      cap_valid_q <= cap_valid_d;
      cap_count_q <= cap_count_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cnt_en    = (state_q == RUN) || (state_q == HOLD);
  assign cnt_clr   = (state_q == CLEAR);
  assign busy      = (state_q != IDLE);
  assign QFlag     = qflag_q;
  assign Qreg      = qreg_q;
  assign cap_valid = cap_valid_q;
  assign cap_count = cap_count_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: directed session scenarios followed by random traffic,
// with every cycle compared against a session-level reference model.
module tb_capture_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] Q = 4'd0;
  logic       cap_ack = 1'b0;
  logic       cnt_en, cnt_clr, QFlag, cap_valid, overrun, busy;
  logic [3:0] Qreg;
  logic [7:0] cap_count;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: session phase (0 off, 1 clearing, 2 active) plus an "armed"
  // marker meaning the counter has reached 15 during this active stretch.
  int m_phase, m_qreg, m_count;
  bit m_armed, m_flag, m_valid, m_over;

  capture_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .Q(Q),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .QFlag(QFlag), .Qreg(Qreg),
    .cap_valid(cap_valid), .cap_ack(cap_ack), .cap_count(cap_count),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit p, input int q, input bit a);
    bit cap;
    if (r) begin
      m_phase = 0; m_armed = 0; m_flag = 0; m_qreg = 0;
      m_valid = 0; m_count = 0; m_over = 0;
      return;
    end
    cap = (m_phase == 2) && m_armed && (q != 15) && !p;
    if (m_phase == 0 && s) begin
      m_count = 0;
      m_over  = 0;
    end
    if (cap) begin
      if (m_count < 255) m_count++;
      if (!m_valid || a) begin
        m_qreg  = q;
        m_valid = 1;
      end else begin
        m_over = 1;
      end
    end else if (m_valid && a) begin
      m_valid = 0;
    end
    if (m_phase != 0 && p) begin
      m_phase = 0; m_armed = 0;
    end else if (m_phase == 0 && s) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2; m_armed = 0;
    end else if (m_phase == 2) begin
      if (cap) m_armed = 0;
      else if (q == 15) m_armed = 1;
    end
    m_flag = (q == 15);
  endtask

  task automatic step(input bit r, input bit s, input bit p, input logic [3:0] q, input bit a);
    reset = r; start = s; stop = p; Q = q; cap_ack = a;
    @(posedge clk);
    model_edge(r, s, p, int'(q), a);
    #1;
    chk("cnt_en",    32'(cnt_en),    32'(m_phase == 2));
    chk("cnt_clr",   32'(cnt_clr),   32'(m_phase == 1));
    chk("busy",      32'(busy),      32'(m_phase != 0));
    chk("QFlag",     32'(QFlag),     32'(m_flag));
    chk("Qreg",      32'(Qreg),      32'(m_qreg));
    chk("cap_valid", 32'(cap_valid), 32'(m_valid));
    chk("cap_count", 32'(cap_count), 32'(m_count));
    chk("overrun",   32'(overrun),   32'(m_over));
  endtask

  initial begin
    step(1, 0, 0, 4'd0, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(cap_count), 0);

    // First session: counter runs 0..15 then wraps to 0.
    step(0, 1, 0, 4'd0, 0);
    chk("clr_pulse", 32'(cnt_clr), 1);
    step(0, 0, 0, 4'd0, 0);
    for (int i = 1; i < 15; i++) step(0, 0, 0, 4'(i), 0);
    step(0, 0, 0, 4'd15, 0);
    chk("qflag_set", 32'(QFlag), 1);
    step(0, 0, 0, 4'd0, 0);
    chk("cap1_qreg", 32'(Qreg), 0);
    chk("cap1_valid", 32'(cap_valid), 1);
    chk("cap1_count", 32'(cap_count), 1);

    // Second pass without ack: old data kept, overrun raised.
    step(0, 0, 0, 4'd5, 0);
    step(0, 0, 0, 4'd15, 0);
    step(0, 0, 0, 4'd7, 0);
    chk("ovr_qreg", 32'(Qreg), 0);
    chk("ovr_count", 32'(cap_count), 2);
    chk("ovr_flag", 32'(overrun), 1);

    // Stop ends the session; a new session with ack coinciding with capture.
    step(0, 0, 1, 4'd8, 0);
    step(0, 1, 0, 4'd0, 0);
    chk("new_sess_ovr", 32'(overrun), 0);
    step(0, 0, 0, 4'd0, 0);
    step(0, 0, 0, 4'd15, 0);
    step(0, 0, 0, 4'd3, 1);
    chk("ackcap_qreg", 32'(Qreg), 3);
    chk("ackcap_valid", 32'(cap_valid), 1);
    chk("ackcap_ovr", 32'(overrun), 0);

    // Stop in HOLD with Q held at 15.
    step(0, 0, 0, 4'd15, 0);
    step(0, 0, 1, 4'd15, 0);
    chk("stop_en", 32'(cnt_en), 0);
    chk("stop_count", 32'(cap_count), 1);

    // Stop in HOLD on the cycle that would otherwise capture.
    step(0, 1, 0, 4'd0, 1);
    step(0, 0, 0, 4'd0, 0);
    step(0, 0, 0, 4'd15, 0);
    step(0, 0, 1, 4'd2, 0);
    chk("stopcap_count", 32'(cap_count), 0);

    // Saturation over many terminal passes.
    step(0, 1, 0, 4'd0, 0);
    step(0, 0, 0, 4'd0, 0);
    for (int i = 0; i < 260; i++) begin
      step(0, 0, 0, 4'd15, 0);
      step(0, 0, 0, 4'd1, 0);
    end
    chk("sat_count", 32'(cap_count), 255);

    // Reset in HOLD with pending data.
    step(0, 0, 0, 4'd15, 0);
    step(1, 0, 0, 4'd0, 0);
    chk("rstmid_valid", 32'(cap_valid), 0);
    chk("rstmid_count", 32'(cap_count), 0);
    chk("rstmid_en", 32'(cnt_en), 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit r, s, p, a;
      logic [3:0] q;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 9) == 0);
      p = ($urandom_range(0, 39) == 0);
      a = ($urandom_range(0, 4) == 0);
      q = ($urandom_range(0, 1) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      step(r, s, p, q, a);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
